rs_enc: RTL and testbench
=========================

# rs_enc

Systematic Reed-Solomon RS(204,188) encoder over GF(2^8) (DVB code, t = 8). It is the transmit-side counterpart of `RS_dec` and uses the same CE-strobed byte-stream handshake. Upstream supplies one byte per CE strobe in 204-strobe block slots. The encoder passes the 188 data bytes through and fills the last 16 slots with parity bytes. Its output can drive `RS_dec` directly in loopback benches.

## Interface
- `N`, 204: codeword length in bytes. Fixed; not user-overridable in practice.
- `K`, 188: data bytes per codeword. N-K = 16 parity bytes.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `CE`  in  1  byte strobe, one clock high per input byte slot; may be high on consecutive cycles.
- `input_byte`  in  8  data byte, sampled on a clk edge where CE=1. Ignored in parity slots 188..203.
- `Out_byte`  out  8  encoded byte, registered.
- `CEO`  out  1  one-clock strobe marking a new `Out_byte`.
- `Valid_out`  out  1  high while an encoded block is being emitted.

## Operation
- Field and code parameters:
  - Field polynomial p(x) = x^8+x^4+x^3+x^2+1 (0x11D); alpha = 0x02.
  - Generator g(x) = prod_{i=0..15} (x + alpha^i), monic, coefficients g0..g15.
  - Multipliers are constant GF multipliers (XOR networks); no lookup RAM.
- State: slot counter `cnt` in 0..203 and parity register bank p[0..15] (8 bits each).
- Data phase, on CE with cnt 0..187:
  - fb = input_byte ^ p[15].
  - p[0] <= g0*fb; p[i] <= p[i-1] ^ gi*fb for i = 1..15.
  - Out_byte <= input_byte.
- Parity phase, on CE with cnt 188..203:
  - Out_byte <= p[15].
  - p[i] <= p[i-1]; p[0] <= 0.
  - input_byte is ignored.
  - After slot 203 all p = 0, so no explicit clear is needed between blocks.
- Counter: cnt increments on each CE and wraps 203 -> 0. It is unchanged when CE=0.
- Output byte order: data bytes 0..187, then parity highest-degree first (p[15] at slot 188, the original p[0] at slot 203).
- Result: codeword c(x) = d(x)*x^16 + (d(x)*x^16 mod g(x)); c(alpha^i) = 0 for i = 0..15.
- Valid_out: set with the CEO of slot 0 and cleared on the clock after the CEO of slot 203. It is therefore low between blocks when CE is idle, and stays continuously high for back-to-back blocks.

## Timing
- Reset values: Out_byte = 0x00, CEO = 0, Valid_out = 0, cnt = 0, all p = 0.
- Latency: CE sampled at edge n -> CEO = 1 and Out_byte valid from edge n until edge n+1. One clock, fixed.
- CEO is high exactly one clock per CE and never high without a preceding CE.
- Throughput: one byte per clock maximum. Arbitrary gaps between CE strobes are allowed and the state holds during gaps.
- Reset mid-block: outputs and state clear immediately. The next CE is treated as slot 0, and the partial block is discarded.
- Reset asserted on the same edge as CE: reset wins and the byte is dropped.

## Test plan
- Zero block: 204 CE strobes, 188 data bytes = 0x00 -> 204 output bytes all 0x00. CEO count = 204; Valid_out high from the first CEO through the last, low one clock later.
- Impulse: data byte 187 = 0x01, all others 0x00 -> output slots 188..203 equal g15..g0 from the golden model, and slot 187 = 0x01.
- Loopback:
  - Stimulus: 100 random 188-byte blocks, CE every 8 clocks, fed through rs_enc into RS_dec.
  - Encoder check: all 16 syndromes of every encoded block = 0.
  - Decoder check: RS_dec outputs equal the original data and the error count = 0.
- Back-to-back stream: CE high every clock for 3 blocks -> 612 consecutive CEOs, Valid_out never drops, and each block's parity matches the model independently.
- Mid-block reset: assert reset for 2 clocks at slot 100 of block 1, then send a fresh block -> all outputs 0 during reset. The new block's parity matches the model as if it were the first block.
- Linearity: enc(A xor B) = enc(A) xor enc(B) for two random blocks, checked over all 204 bytes.

Source files
------------

// File: rtl/rs_enc_if.sv
// Byte-stream bus between the RS(204,188) encoder and its neighbours.
// CE/input_byte flow into the encoder; Out_byte/CEO/Valid_out flow out.
interface rs_enc_if;
    logic       CE;
    logic [7:0] input_byte;
    logic [7:0] Out_byte;
    logic       CEO;
    logic       Valid_out;

    modport master (
        output CE,
        output input_byte,
        input  Out_byte,
        input  CEO,
        input  Valid_out
    );

    modport slave (
        input  CE,
        input  input_byte,
        output Out_byte,
        output CEO,
        output Valid_out
    );
endinterface

// File: rtl/rs_enc.sv
// Systematic RS(204,188) encoder over GF(2^8), p(x)=0x11D, roots alpha^0..alpha^15.
// Data bytes pass through; the 16 parity slots are shifted out of an LFSR, highest degree first.
module rs_enc #(
    parameter int unsigned N = 204,
    parameter int unsigned K = 188
) (
    input  logic    clk,
    input  logic    reset,
    rs_enc_if.slave bus
);
    localparam int unsigned NPAR = N - K;
    localparam int unsigned BW   = 8;
    localparam logic [BW-1:0] K_B    = BW'(K);
    localparam logic [BW-1:0] LAST_B = BW'(N - 1);

    typedef logic [NPAR-1:0][BW-1:0] par_t;
    typedef logic [NPAR:0][BW-1:0]   gfull_t;

    // Shift-and-add GF(2^8) product; with one constant operand it folds to an XOR network.
    function automatic logic [BW-1:0] gf_mul(input logic [BW-1:0] a, input logic [BW-1:0] b);
        logic [BW-1:0] r;
        logic [BW-1:0] x;
        r = '0;
        x = a;
        for (int i = 0; i < int'(BW); i++) begin
            if (b[i]) r = r ^ x;
            x = {x[BW-2:0], 1'b0} ^ (x[BW-1] ? 8'h1D : 8'h00);
        end
        return r;
    endfunction

    // Generator coefficients g0..g15 (ascending degree), evaluated at elaboration.
    function automatic par_t gen_poly();
        gfull_t        c;
        logic [BW-1:0] root;
        c    = '0;
        c[0] = 8'h01;
        root = 8'h01;
        for (int i = 0; i < int'(NPAR); i++) begin
            for (int j = int'(NPAR); j > 0; j--) begin
                c[j] = c[j-1] ^ gf_mul(root, c[j]);
            end
            c[0] = gf_mul(root, c[0]);
            root = gf_mul(root, 8'h02);
        end
        return c[NPAR-1:0];
    endfunction

    localparam par_t G = gen_poly();

    logic [BW-1:0] cnt_q, cnt_d;
    par_t          p_q, p_d;
    logic [BW-1:0] out_q, out_d;
    logic          ceo_q, ceo_d;
    logic          valid_q, valid_d;
    logic [BW-1:0] fb;

    always_comb begin
        cnt_d   = cnt_q;
        p_d     = p_q;
        out_d   = out_q;
        ceo_d   = 1'b0;
        valid_d = valid_q;
        fb      = bus.input_byte ^ p_q[NPAR-1];

        if (bus.CE) begin
            ceo_d   = 1'b1;
            valid_d = 1'b1;
            cnt_d   = (cnt_q == LAST_B) ? '0 : cnt_q + 8'd1;
            if (cnt_q < K_B) begin
                out_d  = bus.input_byte;
                p_d[0] = gf_mul(G[0], fb);
                for (int i = 1; i < int'(NPAR); i++) begin
                    p_d[i] = p_q[i-1] ^ gf_mul(G[i], fb);
                end
            end else begin
                // Parity drain leaves the bank zeroed after the last slot.
                out_d = p_q[NPAR-1];
                p_d   = {p_q[NPAR-2:0], 8'h00};
            end
        end else if (cnt_q == '0) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            p_q     <= '0;
            out_q   <= '0;
            ceo_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            out_q   <= out_d;
            ceo_q   <= ceo_d;
            valid_q <= valid_d;
        end
    end

    assign bus.Out_byte  = out_q;
    assign bus.CEO       = ceo_q;
    assign bus.Valid_out = valid_q;
endmodule

// File: tb/tb_rs_enc.sv
// Bench for rs_enc: textbook polynomial-division model, per-cycle output compare,
// syndrome, linearity and reset checks.
module tb_rs_enc;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    rs_enc_if bus ();
    rs_enc dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;

    logic [7:0] gexp [255];
    int         glog [256];
    logic [7:0] gd   [17];   // generator, descending degree, gd[0] = 1

    logic [7:0] blk  [188];
    logic [7:0] cw   [204];
    logic [7:0] cap  [204];
    logic [7:0] enc_a[204];
    logic [7:0] enc_b[204];
    logic [7:0] blk_a[188];
    logic [7:0] blk_b[188];

    typedef struct {
        logic [7:0] b;
        int         slot;
    } exp_t;
    exp_t expq[$];

    logic ce_seen   = 1'b0;
    int   last_slot = 203;
    int   run_len   = 0;
    int   max_run   = 0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        vectors++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %02h expected %02h", name, act, want);
        end
    endtask

    // Long division of d(x)*x^16 by g(x); remainder fills the parity slots.
    task automatic encode();
        logic [7:0] w [204];
        logic [7:0] c;
        for (int i = 0; i < 204; i++) w[i] = (i < 188) ? blk[i] : 8'h00;
        for (int i = 0; i < 188; i++) begin
            c = w[i];
            for (int j = 1; j <= 16; j++) w[i+j] = w[i+j] ^ gmul(c, gd[j]);
        end
        for (int i = 0; i < 204; i++) cw[i] = (i < 188) ? blk[i] : w[i];
    endtask

    task automatic send_block(input int gap, input int nslots);
        encode();
        for (int s = 0; s < nslots; s++) begin
            expq.push_back('{cw[s], s});
            bus.CE         = 1'b1;
            bus.input_byte = (s < 188) ? blk[s] : 8'($urandom);
            @(posedge clk); #1;
            bus.CE         = 1'b0;
            bus.input_byte = 8'($urandom);
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            vectors++;
            errs++;
            $display("FAIL drain: %0d outputs still pending, expected 0", expq.size());
            expq.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic check_syn(input string name);
        logic [7:0] s;
        for (int i = 0; i < 16; i++) begin
            s = 8'h00;
            for (int k = 0; k < 204; k++) s = gmul(s, gexp[i]) ^ cap[k];
            check($sformatf("%s_syn%0d", name, i), s, 8'h00);
        end
    endtask

    task automatic rand_blk();
        for (int i = 0; i < 188; i++) blk[i] = 8'($urandom);
    endtask

    // Output compare against the expected-byte queue, once per clock on the falling edge.
    always @(posedge clk) ce_seen = bus.CE && !reset;

    always @(negedge clk) begin
        if (reset) begin
            check("reset_out", bus.Out_byte, 8'h00);
            check("reset_flags", {6'b0, bus.CEO, bus.Valid_out}, 8'h00);
            last_slot = 203;
            run_len   = 0;
        end else if (ce_seen) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (expq.size() == 0) begin
                vectors++;
                errs++;
                $display("FAIL unexpected_ceo: got CEO=1 with no pending byte, expected none");
            end else begin
                exp_t e;
                e = expq.pop_front();
                check($sformatf("out_slot%0d", e.slot), bus.Out_byte, e.b);
                check($sformatf("flags_slot%0d", e.slot), {6'b0, bus.CEO, bus.Valid_out}, 8'h03);
                cap[e.slot] = bus.Out_byte;
                last_slot   = e.slot;
            end
        end else begin
            run_len = 0;
            check("idle_flags", {6'b0, bus.CEO, bus.Valid_out}, {7'b0, (last_slot != 203)});
        end
    end

    initial begin
        int x;
        int nz;
        bus.CE         = 1'b0;
        bus.input_byte = 8'h00;

        x = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = 8'(x);
            glog[x] = i;
            x = x << 1;
            if (x > 255) x = x ^ 'h11D;
        end
        for (int i = 0; i < 17; i++) gd[i] = (i == 0) ? 8'h01 : 8'h00;
        for (int i = 0; i < 16; i++) begin
            for (int j = i + 1; j >= 1; j--) gd[j] = gd[j] ^ gmul(gexp[i], gd[j-1]);
        end
        for (int i = 0; i < 204; i++) cap[i] = 8'h00;

        // Pin the model: alpha*0x80 reduces to 0x1D; g15 = sum of roots, g0 = alpha^120, both 0x3B.
        check("model_mul", gmul(8'h80, 8'h02), 8'h1D);
        check("model_g15", gd[1], 8'h3B);
        check("model_g0", gd[16], 8'h3B);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Zero block, CE every other clock.
        for (int i = 0; i < 188; i++) blk[i] = 8'h00;
        send_block(1, 204);
        drain();
        nz = 0;
        for (int i = 0; i < 204; i++) if (cap[i] != 8'h00) nz++;
        check("zero_block_nonzero_count", 8'(nz), 8'h00);
        repeat (3) begin @(posedge clk); #1; end

        // Impulse in the last data slot exposes the generator.
        blk[187] = 8'h01;
        send_block(2, 204);
        drain();
        check("impulse_slot187", cap[187], 8'h01);
        check("impulse_slot188_g15", cap[188], 8'h3B);
        check("impulse_slot203_g0", cap[203], 8'h3B);
        check_syn("impulse");

        // Random blocks, CE every 8 clocks.
        for (int b = 0; b < 6; b++) begin
            rand_blk();
            send_block(7, 204);
            drain();
            check_syn($sformatf("rand%0d", b));
        end

        // Back-to-back stream of three blocks.
        max_run = 0;
        for (int b = 0; b < 3; b++) begin
            rand_blk();
            send_block(0, 204);
        end
        drain();
        check("b2b_run_hi", 8'(max_run >> 8), 8'(612 >> 8));
        check("b2b_run_lo", 8'(max_run), 8'(612));

        // Reset two clocks at slot 100, then a fresh block.
        rand_blk();
        send_block(1, 100);
        reset = 1'b1;
        expq.delete();
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rand_blk();
        send_block(0, 204);
        drain();
        check_syn("after_reset");

        // Reset on the same edge as a CE: the byte is dropped.
        reset          = 1'b1;
        bus.CE         = 1'b1;
        bus.input_byte = 8'hAA;
        expq.delete();
        @(posedge clk); #1;
        bus.CE = 1'b0;
        reset  = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rand_blk();
        send_block(1, 204);
        drain();
        check_syn("reset_with_ce");

        // Linearity: enc(A^B) == enc(A)^enc(B).
        rand_blk();
        for (int i = 0; i < 188; i++) blk_a[i] = blk[i];
        send_block(0, 204);
        drain();
        for (int i = 0; i < 204; i++) enc_a[i] = cap[i];
        rand_blk();
        for (int i = 0; i < 188; i++) blk_b[i] = blk[i];
        send_block(0, 204);
        drain();
        for (int i = 0; i < 204; i++) enc_b[i] = cap[i];
        for (int i = 0; i < 188; i++) blk[i] = blk_a[i] ^ blk_b[i];
        send_block(0, 204);
        drain();
        for (int i = 0; i < 204; i++) check($sformatf("linear%0d", i), cap[i], enc_a[i] ^ enc_b[i]);

        repeat (3) begin @(posedge clk); #1; end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
